// File: rtl/mult_feeder_if.sv
// Feeder handshake bundle: upstream valid/ready vector port plus the
// no-backpressure valid/stationary/data triple toward the multiplier array.
interface mult_feeder_if #(
  parameter int IN_DATA_TYPE = 16,
  parameter int NUM_PES      = 64,
  parameter int CNT_W        = 16
);
  localparam int BW = NUM_PES * IN_DATA_TYPE;

  logic             i_start;
  logic [CNT_W-1:0] i_num_stream;
  logic             i_hold;
  logic             i_data_valid;
  logic [BW-1:0]    i_data_bus;
  logic             o_data_ready;
  logic             o_valid;
  logic             o_stationary;
  logic [BW-1:0]    o_data_bus;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_num_stream, i_hold,
    output i_data_valid, i_data_bus,
    input  o_data_ready, o_valid, o_stationary,
    input  o_data_bus, o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_stream, i_hold,
    input  i_data_valid, i_data_bus,
    output o_data_ready, o_valid, o_stationary,
    output o_data_bus, o_busy, o_done
  );
endinterface

// File: rtl/mult_feeder.sv
// Multiplier-array feeder: one stationary beat then N streaming beats,
// all array-side outputs registered with one-cycle latency.
module mult_feeder #(
  parameter int IN_DATA_TYPE = 16,
  parameter int NUM_PES      = 64,
  parameter int CNT_W        = 16
) (
  input logic         CLK,
  input logic         rst,
  mult_feeder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    STAT,
    STREAM
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem_cnt;
  logic             accept;

  assign bus.o_data_ready = (state == STAT || state == STREAM)
                            && !bus.i_hold;
  assign accept     = bus.i_data_valid && bus.o_data_ready;
  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rem_cnt          <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_stationary <= 1'b0;
      bus.o_data_bus   <= '0;
      bus.o_done       <= 1'b0;
    end else begin
      bus.o_valid      <= 1'b0;
      bus.o_stationary <= 1'b0;
      bus.o_done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            rem_cnt <= bus.i_num_stream;
            state   <= STAT;
          end
        end
        STAT: begin
          if (accept) begin
            bus.o_data_bus   <= bus.i_data_bus;
            bus.o_valid      <= 1'b1;
            bus.o_stationary <= 1'b1;
            if (rem_cnt == '0) begin
              state      <= IDLE;
              bus.o_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            bus.o_data_bus <= bus.i_data_bus;
            bus.o_valid    <= 1'b1;
            rem_cnt        <= rem_cnt - CNT_W'(1);
            // Last streaming beat: count was 1 before this decrement.
            if (rem_cnt == CNT_W'(1)) begin
              state      <= IDLE;
              bus.o_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_feeder.sv
// Randomized scoreboard bench for mult_feeder: jobs push their expected
// beat list up front; a negedge monitor pops and compares each output beat.
module tb_mult_feeder;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int CW = 4;
  localparam int BW = DW * NP;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          stat;
    logic          done;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_feeder_if #(.IN_DATA_TYPE(DW), .NUM_PES(NP), .CNT_W(CW)) bus ();

  mult_feeder #(.IN_DATA_TYPE(DW), .NUM_PES(NP), .CNT_W(CW)) dut (
    .CLK(clk),
    .rst(rst),
    .bus(bus)
  );

  beat_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [BW-1:0] last_bus = '0;

  task automatic chk_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got o_valid=1 data=%h required no beat",
                   bus.o_data_bus);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk_v("beat_data", bus.o_data_bus, e.data);
          chk_b("beat_stat", bus.o_stationary, e.stat);
          chk_b("beat_done", bus.o_done, e.done);
          last_bus = e.data;
        end
      end else begin
        chk_b("bubble_stat", bus.o_stationary, 1'b0);
        chk_b("bubble_done", bus.o_done, 1'b0);
        chk_v("bubble_hold_bus", bus.o_data_bus, last_bus);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk_b({tag, "_valid"}, bus.o_valid, 1'b0);
    chk_b({tag, "_stat"}, bus.o_stationary, 1'b0);
    chk_v({tag, "_bus"}, bus.o_data_bus, '0);
    chk_b({tag, "_busy"}, bus.o_busy, 1'b0);
    chk_b({tag, "_done"}, bus.o_done, 1'b0);
    chk_b({tag, "_ready"}, bus.o_data_ready, 1'b0);
  endtask

  // Called at posedge+1. abort_after>=0 resets the DUT once that many
  // vectors have been accepted.
  task automatic run_job(input int num, input int gap_pct, input int hold_pct,
                         input bit poke, input int abort_after,
                         input bit use_first, input logic [BW-1:0] first);
    logic [BW-1:0] vec[$];
    int k = 0;
    int budget = 0;
    for (int i = 0; i <= num; i++) begin
      logic [BW-1:0] v;
      v = (i == 0 && use_first) ? first : BW'($urandom);
      vec.push_back(v);
      exp_q.push_back('{data: v, stat: (i == 0), done: (i == num)});
    end
    bus.i_start      = 1'b1;
    bus.i_num_stream = CW'(num);
    @(posedge clk); #1;
    bus.i_start      = 1'b0;
    bus.i_num_stream = CW'($urandom);
    chk_b("busy_after_start", bus.o_busy, 1'b1);
    while (k <= num) begin
      bit v;
      bit h;
      if (abort_after >= 0 && k == abort_after) begin
        bus.i_data_valid = 1'b0;
        bus.i_hold       = 1'b0;
        bus.i_start      = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        last_bus = '0;
        bus.i_data_valid = 1'b1;
        #1;
        check_all_zero("reset_mid_job");
        repeat (2) @(posedge clk);
        #1;
        chk_b("no_done_in_reset", bus.o_done, 1'b0);
        bus.i_data_valid = 1'b0;
        rst = 1'b0;
        return;
      end
      v = ($urandom_range(99) >= 32'(gap_pct));
      h = ($urandom_range(99) < 32'(hold_pct));
      bus.i_data_valid = v;
      bus.i_hold       = h;
      bus.i_data_bus   = v ? vec[k] : BW'($urandom);
      bus.i_start      = poke && ($urandom_range(3) == 0);
      bus.i_num_stream = CW'($urandom);
      @(negedge clk);
      chk_b("ready_in_job", bus.o_data_ready, !h);
      chk_b("busy_in_job", bus.o_busy, 1'b1);
      @(posedge clk); #1;
      if (v && !h) k++;
      budget++;
      if (budget > 2000) begin
        checks++;
        errors++;
        $display("FAIL job_timeout: got %0d of %0d accepts", k, num + 1);
        break;
      end
    end
    bus.i_start      = 1'b0;
    bus.i_hold       = 1'b0;
    bus.i_data_valid = 1'b1;
    chk_b("busy_after_last", bus.o_busy, 1'b0);
    @(negedge clk);
    chk_b("ready_idle", bus.o_data_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.i_data_valid = 1'b0;
    chk_b("queue_drained", exp_q.size() == 0, 1'b1);
    chk_b("idle_after_job", bus.o_busy, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] lanes;
    bus.i_start      = 1'b0;
    bus.i_num_stream = '0;
    bus.i_hold       = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data_bus   = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int l = 0; l < NP; l++) lanes[l*DW +: DW] = DW'(8'h11 * (l + 1));
    run_job(0, 0, 0, 1'b0, -1, 1'b1, lanes);
    run_job(3, 0, 0, 1'b0, -1, 1'b0, '0);
    run_job(4, 0, 35, 1'b0, -1, 1'b0, '0);
    run_job(5, 50, 0, 1'b1, -1, 1'b0, '0);
    run_job(5, 0, 0, 1'b0, 2, 1'b0, '0);
    run_job(6, 10, 10, 1'b0, -1, 1'b0, '0);
    run_job((1 << CW) - 1, 20, 20, 1'b1, -1, 1'b0, '0);
    for (int j = 0; j < 12; j++) begin
      run_job(int'($urandom_range((1 << CW) - 1)), int'($urandom_range(60)),
              int'($urandom_range(60)), 1'b1, -1, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_feeder.md
# mult_feeder

Sequencer that drives the multiplier-switch array: it accepts operand vectors from an upstream buffer over a valid/ready handshake and emits one stationary beat followed by a programmed number of streaming beats, producing the valid/stationary/data-bus triple the multiplier array consumes. It sits between the operand buffer or distribution network and the multiplier array, whose inputs have no backpressure. All feeder outputs are therefore registered, and each emitted beat lasts exactly one cycle.

## Interface
- IN_DATA_TYPE, 16, bits per PE operand; 16 for bf16, 8 for int8
- NUM_PES, 64, number of multiplier switches, i.e. lanes per vector
- CNT_W, 16, width of the streaming-beat count
- CLK  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- i_start  input  1  starts a job; sampled only in IDLE
- i_num_stream  input  CNT_W  number of streaming beats in the job; latched when i_start is accepted
- i_hold  input  1  downstream stall; forces o_data_ready low
- i_data_valid  input  1  upstream vector valid
- i_data_bus  input  NUM_PES*IN_DATA_TYPE  upstream vector; lane k is bits [k*IN_DATA_TYPE +: IN_DATA_TYPE]
- o_data_ready  output  1  feeder can accept a vector this cycle
- o_valid  output  1  vector on o_data_bus is valid this cycle
- o_stationary  output  1  the current o_valid beat is the stationary operand
- o_data_bus  output  NUM_PES*IN_DATA_TYPE  vector sent to the multiplier array
- o_busy  output  1  state is not IDLE
- o_done  output  1  one-cycle pulse that coincides with the job's final output beat

## Operation
- States:
  - IDLE: if i_start, latch i_num_stream into rem_cnt, then go to STAT.
  - STAT: on accept, emit a stationary beat; if rem_cnt==0, go to IDLE and set o_done, otherwise go to STREAM.
  - STREAM: on accept, emit a streaming beat and decrement rem_cnt; if rem_cnt==1 before the decrement, go to IDLE and set o_done.
- Accept = i_data_valid && o_data_ready.
- o_data_ready = (state==STAT || state==STREAM) && !i_hold. It is combinational and has no dependency on i_data_valid.
- On accept, register o_data_bus <= i_data_bus and set o_valid=1. o_stationary=1 in STAT and 0 in STREAM.
- Without an accept, o_valid=0 and o_stationary=0. o_data_bus holds its last value.
- i_start is ignored outside IDLE; an i_start pulse during a job has no effect.
- i_num_stream is sampled only on the i_start edge in IDLE. Later changes do not affect the running job.
- Gaps are allowed: i_data_valid low or i_hold high simply produces bubbles (o_valid=0). No beat is dropped or duplicated.
- The data path applies no arithmetic or lane reordering; the output is a bit-exact copy of the accepted vector.
- Reset at any point, including mid-job, clears all state and outputs. The in-flight job is abandoned, o_done is not pulsed, and no further beats are emitted.

## Timing
- Reset values: o_valid=0, o_stationary=0, o_data_bus=0, o_busy=0, o_done=0. The state is IDLE, rem_cnt=0, and o_data_ready=0.
- Latency: a vector accepted at edge t appears on the outputs during cycle t+1 (one-cycle latency).
- o_busy goes high in the cycle after i_start is sampled.
- o_done is registered. It is high in the same cycle as the final beat on o_valid, and is never high without o_valid.
- State returns to IDLE at the same edge as the final accept. A new i_start can be sampled at the next edge, so the earliest next stationary accept is two edges after the last accept.
- Back-to-back accepts sustain one beat per cycle.
- Job length is i_num_stream+1 output beats; maximum i_num_stream is 2^CNT_W-1.

## Test plan
- Basic job: i_num_stream=3, i_data_valid held high, vectors A,B,C,D → o_valid high for 4 consecutive cycles carrying A(stat=1),B,C,D(stat=0). o_done is high with D. o_busy drops after D.
- Zero-length job: i_num_stream=0, vector S → a single beat S with o_stationary=1 and o_done=1 in the same cycle; state returns to IDLE.
- Backpressure: i_num_stream=4, i_hold high for 2 cycles mid-stream → o_data_ready=0 during the hold and o_valid shows 2 bubbles. Total 5 beats in order; o_done on the 5th.
- Upstream gaps and ignored start: i_data_valid toggling 1,0,1,0 and an i_start pulse during STREAM → the job completes with the original count and no second job begins.
- Reset mid-job: rst asserted after 2 of 6 beats → all outputs 0 immediately, o_done never pulses, and a new i_start after reset runs a full job correctly.
- Width check: NUM_PES=4, IN_DATA_TYPE=8, lanes 0x11,0x22,0x33,0x44 → o_data_bus=0x44332211 one cycle after accept.
